elevator_request_register: RTL and testbench

Request-capture front end for the 3-floor elevator. It synchronises, debounces and latches the raw hall and car pushbuttons as absolute per-floor pending calls, and tracks the absolute car floor from the controller's position state. Latched calls are re-expressed as the floor-relative request vectors the per-state next-state controllers consume: bit0 = current floor, bit1 = above, bit2 = below. Served calls are cleared when the door opens at a floor.

---
 rtl/elevator_pkg.sv | 44 ++++
 rtl/button_debouncer.sv | 46 ++++
 rtl/elevator_request_register.sv | 89 ++++++++
 tb/tb_elevator_request_register.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared constants and helpers for the elevator request path.
// Floor masks and absolute-to-relative request mapping live here.
package elevator_pkg;

   localparam logic [1:0] POS_FLOOR     = 2'b00;
   localparam logic [1:0] POS_HALF_UP   = 2'b01;
   localparam logic [1:0] POS_HALF_DOWN = 2'b10;

   localparam logic [1:0] DIR_STOP = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;

   localparam int NUM_FLOORS = 3;

   localparam int REL_HERE  = 0;
   localparam int REL_ABOVE = 1;
   localparam int REL_BELOW = 2;

   function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [1:0] floor);
      logic [NUM_FLOORS-1:0] mask;
      mask = '0;
      for (int g = 0; g < NUM_FLOORS; g++) begin
         if (g == int'(floor)) mask[g] = 1'b1;
      end
      return mask;
   endfunction

   // Bit REL_HERE = call at this floor, REL_ABOVE / REL_BELOW = any call beyond.
   function automatic logic [2:0] rel_map(input logic [NUM_FLOORS-1:0] pend,
                                          input logic [1:0] floor);
      logic [2:0] rel;
      rel = '0;
      for (int g = 0; g < NUM_FLOORS; g++) begin
         if (g == int'(floor))
            rel[REL_HERE] = rel[REL_HERE] | pend[g];
         else if (g > int'(floor))
            rel[REL_ABOVE] = rel[REL_ABOVE] | pend[g];
         else
            rel[REL_BELOW] = rel[REL_BELOW] | pend[g];
      end
      return rel;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// One pushbutton: synchroniser chain, debounce counter and a one-cycle
// pulse on each debounced 0->1 transition.
module button_debouncer #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sample;
   logic                   level;
   logic                   level_d;
   logic [CW-1:0]          count;

   assign sample = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= '0;
         level   <= 1'b0;
         level_d <= 1'b0;
         count   <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
         level_d <= level;
         // The toggle happens on the edge that would make the count reach the limit.
         if (sample == level) begin
            count <= '0;
         end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
            level <= ~level;
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

   assign press = level & ~level_d;

endmodule

// File: rtl/elevator_request_register.sv
// Latches debounced hall/car calls per absolute floor, tracks the car floor
// and presents calls relative to the current floor.
module elevator_request_register
   import elevator_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] raw_up,
   input  logic [2:0] raw_down,
   input  logic [2:0] raw_in,
   input  logic [1:0] pos_cur,
   input  logic       open_cur,
   output logic [1:0] floor_cur,
   output logic [2:0] pend_up,
   output logic [2:0] pend_down,
   output logic [2:0] pend_in,
   output logic [2:0] button_up,
   output logic [2:0] button_down,
   output logic [2:0] button_in
);

   logic [2:0] press_up;
   logic [2:0] press_down;
   logic [2:0] press_in;
   logic [2:0] clear_mask;
   logic [1:0] pos_prev;
   logic       unused_bits;

   // No up button on the top floor and no down button on the ground floor.
   assign unused_bits   = raw_up[NUM_FLOORS-1] ^ raw_down[0];
   assign press_up[NUM_FLOORS-1] = 1'b0;
   assign press_down[0]          = 1'b0;

   for (genvar f = 0; f < NUM_FLOORS - 1; f++) begin : g_up
      button_debouncer #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk(clk), .reset_n(reset_n), .raw(raw_up[f]), .press(press_up[f]));
   end

   for (genvar f = 1; f < NUM_FLOORS; f++) begin : g_down
      button_debouncer #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk(clk), .reset_n(reset_n), .raw(raw_down[f]), .press(press_down[f]));
   end

   for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_in
      button_debouncer #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk(clk), .reset_n(reset_n), .raw(raw_in[f]), .press(press_in[f]));
   end

   always_comb begin
      clear_mask = '0;
      if (pos_cur == POS_FLOOR && open_cur) clear_mask = floor_mask(floor_cur);
   end

   // Clear is applied after set so a same-cycle press at the served floor is lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_up   <= '0;
         pend_down <= '0;
         pend_in   <= '0;
      end else begin
         pend_up   <= (pend_up   | press_up)   & ~clear_mask;
         pend_down <= (pend_down | press_down) & ~clear_mask;
         pend_in   <= (pend_in   | press_in)   & ~clear_mask;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pos_prev  <= POS_FLOOR;
         floor_cur <= 2'd0;
      end else begin
         pos_prev <= pos_cur;
         if (pos_cur == POS_FLOOR) begin
            if (pos_prev == POS_HALF_UP && floor_cur != 2'(NUM_FLOORS - 1))
               floor_cur <= floor_cur + 2'd1;
            else if (pos_prev == POS_HALF_DOWN && floor_cur != 2'd0)
               floor_cur <= floor_cur - 2'd1;
         end
      end
   end

   assign button_up   = rel_map(pend_up,   floor_cur);
   assign button_down = rel_map(pend_down, floor_cur);
   assign button_in   = rel_map(pend_in,   floor_cur);

endmodule

// File: tb/tb_elevator_request_register.sv
// Directed bench for elevator_request_register: a step table of held inputs
// with expected outputs, plus hand-written latency, clear-race and reset sequences.
module tb_elevator_request_register;

   typedef struct {
      logic [2:0] up;
      logic [2:0] down;
      logic [2:0] in_b;
      logic [1:0] pos;
      logic       open;
      int         cycles;
      logic [1:0] floor;
      logic [2:0] pu, pd, pi;
      logic [2:0] bu, bd, bi;
   } step_t;

   logic       clk;
   logic       reset_n;
   logic [2:0] raw_up, raw_down, raw_in;
   logic [1:0] pos_cur;
   logic       open_cur;
   logic [1:0] floor_cur;
   logic [2:0] pend_up, pend_down, pend_in;
   logic [2:0] button_up, button_down, button_in;

   int    checks;
   int    errors;
   step_t steps[$];

   elevator_request_register dut (
      .clk(clk), .reset_n(reset_n),
      .raw_up(raw_up), .raw_down(raw_down), .raw_in(raw_in),
      .pos_cur(pos_cur), .open_cur(open_cur),
      .floor_cur(floor_cur),
      .pend_up(pend_up), .pend_down(pend_down), .pend_in(pend_in),
      .button_up(button_up), .button_down(button_down), .button_in(button_in)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int idx, input logic [2:0] act, input logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0d: got %b expected %b", name, idx, act, exp);
      end
   endtask

   task automatic chk_all(input int idx, input logic [1:0] f, input logic [2:0] pu, input logic [2:0] pd,
                          input logic [2:0] pi, input logic [2:0] bu, input logic [2:0] bd,
                          input logic [2:0] bi);
      chk("floor_cur",   idx, {1'b0, floor_cur}, {1'b0, f});
      chk("pend_up",     idx, pend_up,     pu);
      chk("pend_down",   idx, pend_down,   pd);
      chk("pend_in",     idx, pend_in,     pi);
      chk("button_up",   idx, button_up,   bu);
      chk("button_down", idx, button_down, bd);
      chk("button_in",   idx, button_in,   bi);
   endtask

   task automatic add(input logic [2:0] u, input logic [2:0] d, input logic [2:0] i,
                      input logic [1:0] p, input logic o, input int n, input logic [1:0] f,
                      input logic [2:0] pu, input logic [2:0] pd, input logic [2:0] pi,
                      input logic [2:0] bu, input logic [2:0] bd, input logic [2:0] bi);
      step_t s;
      s.up = u; s.down = d; s.in_b = i; s.pos = p; s.open = o; s.cycles = n;
      s.floor = f; s.pu = pu; s.pd = pd; s.pi = pi; s.bu = bu; s.bd = bd; s.bi = bi;
      steps.push_back(s);
   endtask

   task automatic run_steps(input int first, input int last);
      for (int k = first; k <= last; k++) begin
         raw_up   = steps[k].up;
         raw_down = steps[k].down;
         raw_in   = steps[k].in_b;
         pos_cur  = steps[k].pos;
         open_cur = steps[k].open;
         tick(steps[k].cycles);
         chk_all(k, steps[k].floor, steps[k].pu, steps[k].pd, steps[k].pi,
                 steps[k].bu, steps[k].bd, steps[k].bi);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;

      //   up    down  in    pos  op cyc fl  pu    pd    pi    bu    bd    bi
      add(3'b000,3'b000,3'b000,2'b00,0, 8,2'd0,3'b000,3'b000,3'b100,3'b000,3'b000,3'b010); // 0 release
      add(3'b001,3'b000,3'b000,2'b00,0, 3,2'd0,3'b000,3'b000,3'b100,3'b000,3'b000,3'b010); // 1 glitch
      add(3'b000,3'b000,3'b000,2'b00,0, 8,2'd0,3'b000,3'b000,3'b100,3'b000,3'b000,3'b010); // 2
      add(3'b001,3'b000,3'b000,2'b00,0, 6,2'd0,3'b000,3'b000,3'b100,3'b000,3'b000,3'b010); // 3 6-cycle pulse
      add(3'b000,3'b000,3'b000,2'b00,0, 8,2'd0,3'b001,3'b000,3'b100,3'b001,3'b000,3'b010); // 4
      add(3'b000,3'b000,3'b000,2'b01,0, 1,2'd0,3'b001,3'b000,3'b100,3'b001,3'b000,3'b010); // 5
      add(3'b000,3'b000,3'b000,2'b00,0, 1,2'd1,3'b001,3'b000,3'b100,3'b100,3'b000,3'b010); // 6 floor 1
      add(3'b000,3'b000,3'b000,2'b01,0, 1,2'd1,3'b001,3'b000,3'b100,3'b100,3'b000,3'b010); // 7
      add(3'b000,3'b000,3'b000,2'b00,0, 1,2'd2,3'b001,3'b000,3'b100,3'b100,3'b000,3'b001); // 8 floor 2
      add(3'b000,3'b000,3'b000,2'b01,0, 1,2'd2,3'b001,3'b000,3'b100,3'b100,3'b000,3'b001); // 9
      add(3'b000,3'b000,3'b000,2'b00,0, 1,2'd2,3'b001,3'b000,3'b100,3'b100,3'b000,3'b001); // 10 saturate
      add(3'b000,3'b000,3'b001,2'b00,0, 8,2'd2,3'b001,3'b000,3'b101,3'b100,3'b000,3'b101); // 11
      add(3'b000,3'b000,3'b000,2'b00,0, 8,2'd2,3'b001,3'b000,3'b101,3'b100,3'b000,3'b101); // 12
      add(3'b000,3'b000,3'b000,2'b00,1, 1,2'd2,3'b001,3'b000,3'b001,3'b100,3'b000,3'b100); // 13 clear fl2
      add(3'b000,3'b000,3'b000,2'b00,0, 1,2'd2,3'b001,3'b000,3'b001,3'b100,3'b000,3'b100); // 14
      add(3'b000,3'b000,3'b000,2'b10,0, 1,2'd2,3'b001,3'b000,3'b001,3'b100,3'b000,3'b100); // 15
      add(3'b000,3'b000,3'b000,2'b00,0, 1,2'd1,3'b001,3'b000,3'b001,3'b100,3'b000,3'b100); // 16
      add(3'b000,3'b000,3'b000,2'b10,0, 1,2'd1,3'b001,3'b000,3'b001,3'b100,3'b000,3'b100); // 17
      add(3'b000,3'b000,3'b000,2'b00,0, 1,2'd0,3'b001,3'b000,3'b001,3'b001,3'b000,3'b001); // 18 floor 0
      add(3'b000,3'b000,3'b000,2'b00,1, 1,2'd0,3'b000,3'b000,3'b000,3'b000,3'b000,3'b000); // 19 clear fl0
      add(3'b000,3'b000,3'b000,2'b01,0, 1,2'd0,3'b000,3'b000,3'b000,3'b000,3'b000,3'b000); // 20
      add(3'b000,3'b000,3'b000,2'b00,0, 1,2'd1,3'b000,3'b000,3'b000,3'b000,3'b000,3'b000); // 21
      add(3'b000,3'b010,3'b010,2'b00,0, 8,2'd1,3'b000,3'b010,3'b010,3'b000,3'b001,3'b001); // 22
      add(3'b000,3'b000,3'b000,2'b00,0, 8,2'd1,3'b000,3'b010,3'b010,3'b000,3'b001,3'b001); // 23
      add(3'b100,3'b001,3'b000,2'b00,0,10,2'd1,3'b000,3'b000,3'b001,3'b000,3'b000,3'b100); // 24 ignored bits
      add(3'b000,3'b000,3'b000,2'b00,0, 8,2'd1,3'b000,3'b000,3'b001,3'b000,3'b000,3'b100); // 25
      add(3'b000,3'b000,3'b000,2'b11,0, 2,2'd1,3'b000,3'b000,3'b001,3'b000,3'b000,3'b100); // 26 illegal pos
      add(3'b000,3'b000,3'b000,2'b00,0, 1,2'd1,3'b000,3'b000,3'b001,3'b000,3'b000,3'b100); // 27
      add(3'b000,3'b000,3'b000,2'b01,0, 1,2'd1,3'b000,3'b000,3'b001,3'b000,3'b000,3'b100); // 28
      add(3'b000,3'b000,3'b000,2'b00,0, 1,2'd2,3'b000,3'b000,3'b001,3'b000,3'b000,3'b100); // 29
      add(3'b000,3'b000,3'b100,2'b00,0, 8,2'd2,3'b000,3'b000,3'b101,3'b000,3'b000,3'b101); // 30

      reset_n  = 1'b0;
      raw_up   = '0;
      raw_down = '0;
      raw_in   = '0;
      pos_cur  = 2'b00;
      open_cur = 1'b0;
      tick(3);
      chk_all(-1, 2'd0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
      reset_n = 1'b1;

      // press latency: first high sample at the next edge, latch on the 7th
      raw_in = 3'b100;
      tick(6);
      chk("latency_before", 0, pend_in, 3'b000);
      tick(1);
      chk("latency_at", 0, pend_in, 3'b100);
      chk("latency_rel", 0, button_in, 3'b010);

      run_steps(0, 23);

      // door opens at floor 1 in the very cycle raw_in[1:0] presses arrive
      raw_in = 3'b011;
      tick(6);
      open_cur = 1'b1;
      tick(1);
      chk("race_pend_in",   100, pend_in,   3'b001);
      chk("race_pend_down", 100, pend_down, 3'b000);
      chk("race_button_in", 100, button_in, 3'b100);
      open_cur = 1'b0;
      tick(2);
      chk("race_held", 101, pend_in, 3'b001);
      raw_in = 3'b000;
      tick(8);

      run_steps(24, 30);

      // asynchronous reset while calls are pending at floor 2
      #2;
      reset_n = 1'b0;
      #1;
      chk_all(200, 2'd0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
      tick(2);
      reset_n = 1'b1;
      tick(6);
      chk("relatch_before", 201, pend_in, 3'b000);
      tick(1);
      chk("relatch_at", 202, pend_in, 3'b100);
      chk("relatch_rel", 202, button_in, 3'b010);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
